imem_fetch_ctrl: RTL

Fetch sequencer and port arbiter for the 16x8 instruction memory, which has a single port, a registered read with 1-cycle latency, and read-before-write on the same port.
- Owns the program counter and issues reads.
- Delivers each fetched instruction to the decoder over a valid/ready handshake.
- Shares the one memory port with a program-loader write port.
- Sits between the loader/debug logic, the instruction memory and the decode stage.

---
 rtl/imem_fetch_ctrl_if.sv | 33 +++
 rtl/imem_fetch_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of the fetch controller's loader, jump, decode-side and memory-side signals.
// The slave modport is the controller's view; master is the surrounding logic's view.
interface imem_fetch_ctrl_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
);
  logic          run;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          jmp_valid;
  logic [AW-1:0] jmp_addr;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;
  logic [AW-1:0] pc;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  run, ld_valid, ld_addr, ld_data, jmp_valid, jmp_addr, instr_ready, mem_dout,
    output ld_ready, instr_valid, instr, instr_pc, pc, mem_we, mem_addr, mem_din
  );

  modport master (
    output run, ld_valid, ld_addr, ld_data, jmp_valid, jmp_addr, instr_ready, mem_dout,
    input  ld_ready, instr_valid, instr, instr_pc, pc, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for a single-port instruction memory: owns the pc, issues reads,
// hands words to decode over valid/ready and shares the port with the program loader.
module imem_fetch_ctrl #(
  parameter int unsigned AW        = 4,
  parameter int unsigned DW        = 8,
  parameter bit          LOAD_PRIO = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  imem_fetch_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_n;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] instr_pc_q;
  logic [AW-1:0] instr_pc_n;
  logic [DW-1:0] instr_q;
  logic [DW-1:0] instr_n;
  logic          valid_q;
  logic          valid_n;
  logic          grant;
  logic          ld_hits_pc;

  // Loader owns the port whenever the fetch read is not competing, or always when it has priority.
  always_comb begin
    grant      = bus.ld_valid && !rst && ((state != ISSUE) || LOAD_PRIO);
    ld_hits_pc = grant && (bus.ld_addr == pc_q);
    pc_inc     = pc_q + AW'(1);
  end

  assign bus.ld_ready    = grant;
  assign bus.mem_we      = grant;
  assign bus.mem_addr    = grant ? bus.ld_addr : pc_q;
  assign bus.mem_din     = bus.ld_data;
  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state      <= state_n;
      pc_q       <= pc_n;
      instr_q    <= instr_n;
      instr_pc_q <= instr_pc_n;
      valid_q    <= valid_n;
    end
  end

  // A jump always wins; a loader write to the word being captured or held forces a refetch.
  always_comb begin
    state_n    = state;
    pc_n       = pc_q;
    instr_n    = instr_q;
    instr_pc_n = instr_pc_q;
    valid_n    = valid_q;

    unique case (state)
      IDLE: begin
        if (bus.jmp_valid) pc_n = bus.jmp_addr;
        if (bus.run)       state_n = ISSUE;
      end

      ISSUE: begin
        if (bus.jmp_valid) begin
          pc_n = bus.jmp_addr;
        end else if (!grant) begin
          state_n = CAPT;
        end
      end

      CAPT: begin
        if (bus.jmp_valid) begin
          pc_n    = bus.jmp_addr;
          state_n = ISSUE;
        end else if (ld_hits_pc) begin
          state_n = ISSUE;
        end else begin
          instr_n    = bus.mem_dout;
          instr_pc_n = pc_q;
          valid_n    = 1'b1;
          state_n    = HOLD;
        end
      end

      HOLD: begin
        if (bus.instr_ready) begin
          valid_n = 1'b0;
          if (bus.jmp_valid) begin
            pc_n    = bus.jmp_addr;
            state_n = ISSUE;
          end else begin
            pc_n    = pc_inc;
            state_n = bus.run ? ISSUE : IDLE;
          end
        end else if (bus.jmp_valid) begin
          pc_n    = bus.jmp_addr;
          valid_n = 1'b0;
          state_n = ISSUE;
        end else if (ld_hits_pc) begin
          valid_n = 1'b0;
          state_n = ISSUE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule
